bus_cycle_arbiter: RTL and testbench
====================================

Name: bus_cycle_arbiter

Overview:
- Shares the single multiplexed external address/data bus between two requesters: port 0 (instruction fetch) and port 1 (data/display access).
- Sequences each transfer as ALE address phase, hold, En strobe and recovery; drives ALE/En/Rw directly to the pins.
- Sits between the core and the top-level pad outputs; the external pause input freezes new grants.

Parameters:
- DW, 8, width of the multiplexed bus; address and data are both DW bits.
- STROBE_CYCLES, 2, number of cycles En is held high; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pause  input  1  1 = grant no new transfer; an in-flight transfer still completes
- req0, req1  input  1 each  transfer request; held high until the matching ack
- rw0, rw1  input  1 each  1 = read, 0 = write
- addr0, addr1  input  DW each  transfer address
- wdata0, wdata1  input  DW each  write data
- ack0, ack1  output  1 each  one-cycle completion pulse
- rdata  output  DW  read data; valid in the ack cycle, held until the next read captures
- busy  output  1  high in every non-IDLE state
- gnt_id  output  1  port of the current or last transfer
- ale  output  1  address latch enable
- en  output  1  bus strobe
- rw  output  1  bus direction (1 = read)
- ad_out  output  DW  bus drive value
- ad_oe  output  1  bus output enable
- ad_in  input  DW  bus sampled value

Behaviour:
- Reset values (asynchronous, immediate): state = IDLE, ale = 0, en = 0, rw = 1, ad_oe = 0, ad_out = 0, ack0 = ack1 = 0, rdata = 0, busy = 0, gnt_id = 0, last_grant = 1.
- States are IDLE, ADDR, HOLD, STROBE and RECOVER.
- IDLE:
  - If pause = 0 and any req is high, grant and go to ADDR.
  - The granted port's rw/addr/wdata are latched into internal registers on that edge.
  - Requester inputs are ignored after the latch.
- Arbitration is round-robin:
  - If only one req is high, that port wins.
  - If both are high, the port not equal to last_grant wins.
  - last_grant and gnt_id update at grant.
  - The first contested grant after reset goes to port 0.
- ADDR (1 cycle): ale = 1, ad_oe = 1, ad_out = latched addr, en = 0, rw = latched rw.
- HOLD (1 cycle): ale = 0; address still driven and rw held.
- STROBE (STROBE_CYCLES cycles, via an internal counter):
  - en = 1.
  - Write: ad_oe = 1, ad_out = wdata.
  - Read: ad_oe = 0, ad_out = 0.
- Read capture: rdata is sampled from ad_in at the clock edge that ends the last STROBE cycle.
- RECOVER (1 cycle):
  - en = 0; ack of the granted port = 1.
  - A write keeps driving wdata for this cycle (data hold).
  - A read keeps ad_oe = 0.
  - Next state is always IDLE; rw returns to 1 in IDLE.
- Latency: req seen in IDLE at cycle k gives ADDR at k+1, ack at k+3+STROBE_CYCLES (k+5 by default).
- Back-to-back transfers: minimum period is 4+STROBE_CYCLES cycles, because IDLE always lasts at least one cycle.
- Requester obligation: deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Pause:
  - Sampled only in IDLE.
  - Asserting pause mid-transfer has no effect until the transfer returns to IDLE.
  - Requests stay pending while paused.
- Never drive ale and en high in the same cycle. Assert exactly one ack per granted transfer.
- Reset mid-transfer:
  - Strobes drop immediately; no ack is issued.
  - Latched request data is discarded.
  - The requester must re-request.

Test Plan:
- Single read, port 0: addr0 = 0x3C, ad_in = 0xA5 during STROBE -> ale high 1 cycle with ad_out = 0x3C, en high 2 cycles with ad_oe = 0, ack0 at k+5, rdata = 0xA5.
- Single write, port 1: addr1 = 0x10, wdata1 = 0x7E -> rw = 0 from ADDR to RECOVER, ad_out = 0x7E with ad_oe = 1 in STROBE and RECOVER, ack1 once, ack0 never.
- Contention: req0 and req1 both held high continuously -> grants alternate 0,1,0,1 starting with port 0; ack period 6 cycles.
- Pause: pause = 1 with req0 high -> ale/en stay 0 and busy = 0. Release pause -> ADDR on the next cycle. Pause asserted during STROBE -> the transfer still acks.
- Reset mid-transfer: rst_n low during STROBE -> en, ale and ad_oe go to 0 immediately, no ack. After release with req1 high, a fresh ADDR cycle with port 1 is granted.
- STROBE_CYCLES = 1 and 4 builds -> en width equals the parameter and ack latency is k+4 and k+7 respectively.

Source files
------------

// File: rtl/bus_cycle_arbiter.sv
// Purpose: two-port round-robin arbiter/sequencer for the multiplexed external address/data bus.
// Latency: a req seen in IDLE at cycle k gives ALE at k+1 and an ack at k+3+STROBE_CYCLES.
// Backpressure: pause holds off new grants only; requests stay pending and an in-flight transfer completes.
module bus_cycle_arbiter #(
    parameter int DW            = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pause,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          gnt_id,
    output logic          ale,
    output logic          en,
    output logic          rw,
    output logic [DW-1:0] ad_out,
    output logic          ad_oe,
    input  logic [DW-1:0] ad_in
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        HOLD    = 3'd2,
        STROBE  = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic          rw_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          gnt_q;
    logic          last_grant;
    logic          grant_go;
    logic          win;
    logic          strobe_last;

    // A grant happens only from IDLE with pause low; on contention the port not served last wins.
    assign grant_go    = (state == IDLE) && !pause && (req0 || req1);
    assign win         = (req0 && req1) ? ~last_grant : req1;
    assign strobe_last = (cnt == 4'(STROBE_CYCLES - 1));
    assign gnt_id      = gnt_q;

    // State register; reset forces IDLE so all strobes decode low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pin decode; outputs are pure functions of state and latched request.
    always_comb begin
        state_nxt = state;
        ale       = 1'b0;
        en        = 1'b0;
        rw        = 1'b1;
        ad_oe     = 1'b0;
        ad_out    = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_go) state_nxt = ADDR;
            end
            ADDR: begin
                ale       = 1'b1;
                ad_oe     = 1'b1;
                ad_out    = addr_q;
                rw        = rw_q;
                state_nxt = HOLD;
            end
            HOLD: begin
                ad_oe     = 1'b1;
                ad_out    = addr_q;
                rw        = rw_q;
                state_nxt = STROBE;
            end
            STROBE: begin
                en = 1'b1;
                rw = rw_q;
                if (!rw_q) begin
                    ad_oe  = 1'b1;
                    ad_out = wdata_q;
                end
                if (strobe_last) state_nxt = RECOVER;
            end
            RECOVER: begin
                rw = rw_q;
                // Write data is held one extra cycle past the strobe's falling edge.
                if (!rw_q) begin
                    ad_oe  = 1'b1;
                    ad_out = wdata_q;
                end
                ack0      = ~gnt_q;
                ack1      = gnt_q;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winning request at grant; requester inputs are not looked at again until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q       <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_go) begin
            rw_q       <= win ? rw1 : rw0;
            addr_q     <= win ? addr1 : addr0;
            wdata_q    <= win ? wdata1 : wdata0;
            gnt_q      <= win;
            last_grant <= win;
        end
    end

    // Strobe-width counter and read capture on the edge closing the last strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rdata <= '0;
        end else begin
            if (state == STROBE) cnt <= cnt + 4'd1;
            else                 cnt <= '0;
            if (state == STROBE && strobe_last && rw_q) rdata <= ad_in;
        end
    end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Directed bench for bus_cycle_arbiter: default build plus STROBE_CYCLES=1 and =4 builds on shared inputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same offset.
// Each scenario task does its own inline comparisons; one summary line at the end.
module tb_bus_cycle_arbiter;

    logic       clk = 1'b0;
    logic       rst_n, pause, req0, req1, rw0, rw1;
    logic [7:0] addr0, addr1, wdata0, wdata1, ad_in;

    logic       ack0, ack1, busy, gnt_id, ale, en, rw, ad_oe;
    logic [7:0] rdata, ad_out;
    logic       a1_ack0, a1_ack1, a1_busy, a1_gnt, a1_ale, a1_en, a1_rw, a1_oe;
    logic [7:0] a1_rdata, a1_ad_out;
    logic       a4_ack0, a4_ack1, a4_busy, a4_gnt, a4_ale, a4_en, a4_rw, a4_oe;
    logic [7:0] a4_rdata, a4_ad_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_cycle_arbiter #(.DW(8), .STROBE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .req0(req0), .req1(req1),
        .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
        .ale(ale), .en(en), .rw(rw), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    bus_cycle_arbiter #(.DW(8), .STROBE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .pause(pause), .req0(req0), .req1(req1),
        .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(a1_ack0), .ack1(a1_ack1), .rdata(a1_rdata), .busy(a1_busy), .gnt_id(a1_gnt),
        .ale(a1_ale), .en(a1_en), .rw(a1_rw), .ad_out(a1_ad_out), .ad_oe(a1_oe), .ad_in(ad_in)
    );

    bus_cycle_arbiter #(.DW(8), .STROBE_CYCLES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .pause(pause), .req0(req0), .req1(req1),
        .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(a4_ack0), .ack1(a4_ack1), .rdata(a4_rdata), .busy(a4_busy), .gnt_id(a4_gnt),
        .ale(a4_ale), .en(a4_en), .rw(a4_rw), .ad_out(a4_ad_out), .ad_oe(a4_oe), .ad_in(ad_in)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        pause = 1'b0; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00; ad_in = 8'h00;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        req0  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ale, en, ad_oe, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: ale/en/ad_oe/busy=%b required 0000", {ale, en, ad_oe, busy});
        end
        checks++;
        if (rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b required 1", rw); end
        checks++;
        if (ad_out !== 8'h00) begin errors++; $display("FAIL reset_ad_out: got %h required 00", ad_out); end
        checks++;
        if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b required 00", {ack0, ack1}); end
        checks++;
        if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h required 00", rdata); end
        checks++;
        if (gnt_id !== 1'b0) begin errors++; $display("FAIL reset_gnt_id: got %b required 0", gnt_id); end
        req0  = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read;
        int ale_n = 0, en_n = 0, ack0_i = -1, ack0_n = 0, ack1_n = 0, bad_addr = 0, bad_oe = 0, overlap = 0;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h3C; ad_in = 8'hA5;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (ale) begin ale_n++; if (ad_out !== 8'h3C || ad_oe !== 1'b1) bad_addr++; end
            if (en) begin en_n++; if (ad_oe !== 1'b0) bad_oe++; end
            if (ale && en) overlap++;
            if (ack1) ack1_n++;
            if (ack0) begin
                ack0_n++;
                if (ack0_i < 0) ack0_i = i;
                checks++;
                if (rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h required a5", rdata); end
                req0 = 1'b0;
            end
        end
        ad_in = 8'h00;
        checks++;
        if (ale_n != 1) begin errors++; $display("FAIL read_ale_width: got %0d required 1", ale_n); end
        checks++;
        if (bad_addr != 0) begin errors++; $display("FAIL read_addr_phase: bad cycles %0d required 0", bad_addr); end
        checks++;
        if (en_n != 2) begin errors++; $display("FAIL read_en_width: got %0d required 2", en_n); end
        checks++;
        if (bad_oe != 0) begin errors++; $display("FAIL read_oe_in_strobe: bad cycles %0d required 0", bad_oe); end
        checks++;
        if (ack0_i != 5 || ack0_n != 1) begin
            errors++; $display("FAIL read_ack0: cycle %0d count %0d required cycle 5 count 1", ack0_i, ack0_n);
        end
        checks++;
        if (ack1_n != 0 || overlap != 0) begin
            errors++; $display("FAIL read_stray: ack1 %0d ale&en %0d required 0 0", ack1_n, overlap);
        end
        checks++;
        if (rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata_hold: got %h required a5", rdata); end
    endtask

    task automatic test_single_write;
        int busy_n = 0, bad_rw = 0, bad_data = 0, ack1_n = 0, ack0_n = 0, rec_ok = 0, bad_gnt = 0;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h7E; ad_in = 8'h5A;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (busy) begin
                busy_n++;
                if (rw !== 1'b0) bad_rw++;
                if (gnt_id !== 1'b1) bad_gnt++;
            end
            if (en && (ad_out !== 8'h7E || ad_oe !== 1'b1)) bad_data++;
            if (ack0) ack0_n++;
            if (ack1) begin
                ack1_n++;
                if (ad_out === 8'h7E && ad_oe === 1'b1 && en === 1'b0) rec_ok++;
                req1 = 1'b0;
            end
        end
        checks++;
        if (busy_n != 5 || bad_rw != 0) begin
            errors++; $display("FAIL write_rw_low: busy %0d bad rw %0d required 5 0", busy_n, bad_rw);
        end
        checks++;
        if (bad_data != 0) begin errors++; $display("FAIL write_strobe_data: bad cycles %0d required 0", bad_data); end
        checks++;
        if (rec_ok != 1) begin errors++; $display("FAIL write_data_hold: got %0d required 1", rec_ok); end
        checks++;
        if (ack1_n != 1 || ack0_n != 0) begin
            errors++; $display("FAIL write_acks: ack1 %0d ack0 %0d required 1 0", ack1_n, ack0_n);
        end
        checks++;
        if (bad_gnt != 0) begin errors++; $display("FAIL write_gnt_id: bad cycles %0d required 0", bad_gnt); end
        checks++;
        if (rdata !== 8'hA5) begin errors++; $display("FAIL write_rdata_kept: got %h required a5", rdata); end
    endtask

    task automatic test_back_to_back;
        int   ack_t[8];
        logic ack_p[8];
        int   n = 0, both = 0;
        int   exp_t[4] = '{5, 11, 17, 23};
        logic exp_p[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        req0 = 1'b1; req1 = 1'b1; rw0 = 1'b1; rw1 = 1'b1; addr0 = 8'h01; addr1 = 8'h02;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (ack0 && ack1) both++;
            if ((ack0 || ack1) && n < 8) begin ack_t[n] = i; ack_p[n] = ack1; n++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (n != 4 || both != 0) begin errors++; $display("FAIL rr_ack_count: got %0d (dual %0d) required 4 (0)", n, both); end
        for (int j = 0; j < 4; j++) begin
            if (j < n) begin
                checks++;
                if (ack_t[j] != exp_t[j] || ack_p[j] !== exp_p[j]) begin
                    errors++;
                    $display("FAIL rr_grant%0d: cycle %0d port %b required cycle %0d port %b",
                             j, ack_t[j], ack_p[j], exp_t[j], exp_p[j]);
                end
            end
        end
        step();
    endtask

    task automatic test_pause;
        int viol = 0;
        logic seen = 1'b0;
        do_reset();
        pause = 1'b1; req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h44;
        repeat (5) begin
            step();
            if (ale || en || busy) viol++;
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL pause_hold: active cycles %0d required 0", viol); end
        pause = 1'b0;
        step();
        checks++;
        if (ale !== 1'b1 || ad_out !== 8'h44) begin
            errors++; $display("FAIL pause_release: ale %b ad_out %h required 1 44", ale, ad_out);
        end
        step();
        step();
        pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack0) begin seen = 1'b1; req0 = 1'b0; break; end
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL pause_midflight_ack: ack0 seen %b required 1", seen); end
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL pause_idle_after: busy %b required 0", busy); end
        pause = 1'b0;
    endtask

    task automatic test_reset_midflight;
        int   rst_acks = 0;
        logic seen = 1'b0;
        do_reset();
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h31; wdata0 = 8'h99;
        repeat (3) step();
        checks++;
        if (en !== 1'b1 || ad_oe !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: en %b ad_oe %b required 1 1", en, ad_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en, ale, ad_oe, ack0, busy} !== 5'b00000) begin
            errors++; $display("FAIL rstmid_drop: en/ale/oe/ack0/busy=%b required 00000", {en, ale, ad_oe, ack0, busy});
        end
        req0 = 1'b0; req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h55;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (ack0 || ack1) rst_acks++;
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (ale !== 1'b1 || gnt_id !== 1'b1 || ad_out !== 8'h55) begin
            errors++; $display("FAIL rstmid_regrant: ale %b gnt %b ad_out %h required 1 1 55", ale, gnt_id, ad_out);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack0) rst_acks++;
            if (ack1) begin seen = 1'b1; req1 = 1'b0; break; end
        end
        checks++;
        if (seen !== 1'b1 || rst_acks != 0) begin
            errors++; $display("FAIL rstmid_acks: ack1 %b stray %0d required 1 0", seen, rst_acks);
        end
    endtask

    task automatic test_strobe_params;
        int e1 = 0, e4 = 0, t1 = -1, t4 = -1, t2 = -1;
        do_reset();
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h22; ad_in = 8'h6B;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (t1 < 0 && a1_en) e1++;
            if (t4 < 0 && a4_en) e4++;
            if (t1 < 0 && a1_ack0) t1 = i;
            if (t2 < 0 && ack0) t2 = i;
            if (t4 < 0 && a4_ack0) begin
                t4 = i;
                req0 = 1'b0;
                checks++;
                if (a4_rdata !== 8'h6B) begin errors++; $display("FAIL s4_rdata: got %h required 6b", a4_rdata); end
            end
        end
        checks++;
        if (e1 != 1 || t1 != 4) begin errors++; $display("FAIL s1_timing: en %0d ack %0d required 1 4", e1, t1); end
        checks++;
        if (e4 != 4 || t4 != 7) begin errors++; $display("FAIL s4_timing: en %0d ack %0d required 4 7", e4, t4); end
        checks++;
        if (t2 != 5) begin errors++; $display("FAIL s2_timing: ack %0d required 5", t2); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_pause();
        test_reset_midflight();
        test_strobe_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
